sgd_gradient_batch_acc: RTL and testbench

Mini-batch gradient accumulator sitting directly upstream of the x_updated read/modify/write stage. Per bank word it sums per-sample gradient contributions across `batch_size` samples in an internal buffer. On the last sample of each batch it emits the summed word on `acc_gradient` / `acc_gradient_valid`, which the downstream stage subtracts from x_updated.

---
 rtl/sgd_pkg.sv | 44 ++++
 rtl/sgd_acc_bram.sv | 39 +++
 rtl/sgd_gradient_batch_acc.sv | 163 ++++++++++++++++
 tb/tb_sgd_gradient_batch_acc.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sgd_pkg.sv
// Shared definitions for the SGD gradient datapath.
// Holds the bank/engine geometry constants (same values as the shared
// sgd_defines.vh), the per-sample phase enum, the beat descriptor carried
// down the accumulator pipeline, and a lane-wise add helper.
package sgd_pkg;

  localparam int NUM_BITS_PER_BANK  = 8;   // 32-bit lanes per bank word
  localparam int BIT_WIDTH_OF_BANK  = 3;
  localparam int ENGINE_NUM_WIDTH   = 3;
  localparam int DIS_X_BIT_DEPTH    = 4;   // log2 of bank words per model
  localparam int MAX_BIT_WIDTH_OF_X = 10;

  localparam int LANE_W     = 32;
  localparam int LANE_VEC_W = NUM_BITS_PER_BANK * LANE_W;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_FIRST,
    PH_MID,
    PH_LAST
  } phase_e;

  // One accepted gradient beat as it travels through the pipeline.
  typedef struct packed {
    logic [DIS_X_BIT_DEPTH-1:0] addr;
    logic                       first;  // ignore the buffer, start from zero
    logic                       last;   // emit instead of writing back
    logic [LANE_VEC_W-1:0]      grad;
  } beat_t;

  // Per-lane two's-complement add; each lane wraps independently.
  function automatic logic [LANE_VEC_W-1:0] add_lanes(
    input logic [LANE_VEC_W-1:0] a,
    input logic [LANE_VEC_W-1:0] b
  );
    logic [LANE_VEC_W-1:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_BITS_PER_BANK; i++) begin
      sum[i*LANE_W +: LANE_W] = a[i*LANE_W +: LANE_W] + b[i*LANE_W +: LANE_W];
    end
    return sum;
  endfunction

endpackage

// File: rtl/sgd_acc_bram.sv
// Simple dual-port RAM holding the partial batch sums, one bank word per
// address. Registered read (1-cycle latency), read-first on a same-edge
// collision, written in the block-RAM inference template.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address, sampled every cycle
//   rdata_o  - read data, valid one cycle after raddr_i
module sgd_acc_bram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  // NOTE: the array has no reset; a reset would block BRAM inference, and
  // every batch overwrites each word on its first sample anyway.
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: clocked state uses non-blocking assignments only, so the read
  // sees the pre-write contents regardless of statement order.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sgd_gradient_batch_acc.sv
// Mini-batch gradient accumulator. Sums per-sample gradient bank words over
// batch_size samples and emits the summed word on the last sample.
// Pipeline: C0 accept + read issue, C1 RAM data + bypass, C2 add,
// C3 write back (FIRST/MID) or register output (LAST).
// Ports:
//   clk, rst           - clock, synchronous active-high reset
//   started            - job running; low holds counters at zero
//   dimension          - model dimension, gives words per sample
//   batch_size         - samples per batch (0 treated as 1)
//   gradient(_valid)   - one bank word of the current sample
//   acc_gradient(_valid) - batch-summed bank word, 3 cycles after LAST beat
module sgd_gradient_batch_acc
  import sgd_pkg::*;
#(
  parameter int DATA_WIDTH_IN      = 4,
  parameter int MAX_DIMENSION_BITS = MAX_BIT_WIDTH_OF_X
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         started,
  input  logic [31:0]                  dimension,
  input  logic [31:0]                  batch_size,
  input  logic [LANE_VEC_W-1:0]        gradient,
  input  logic                         gradient_valid,
  output logic [LANE_VEC_W-1:0]        acc_gradient,
  output logic [NUM_BITS_PER_BANK-1:0] acc_gradient_valid
);

  localparam int AW    = DIS_X_BIT_DEPTH;
  localparam int SHIFT = BIT_WIDTH_OF_BANK + ENGINE_NUM_WIDTH;
  localparam int WW    = MAX_DIMENSION_BITS - SHIFT + 1;

  // Job geometry, rounded up to whole bank words.
  logic [WW-1:0] words_w, words_m1_w;
  logic [AW-1:0] words_m1_q;
  logic [31:0]   batch_m1_q;

  assign words_w    = WW'(dimension[MAX_DIMENSION_BITS-1:SHIFT])
                    + WW'(|dimension[SHIFT-1:0]);
  assign words_m1_w = words_w - WW'(1);

  // Bits beyond the supported range, and the precision tag, carry no function.
  logic unused_cfg;
  assign unused_cfg = ^{dimension[31:MAX_DIMENSION_BITS], words_m1_w[WW-1:AW]}
                    ^ (DATA_WIDTH_IN == 0);

  // Counters and phase.
  logic [AW-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]   sample_cnt_q, sample_cnt_d;
  phase_e        phase;
  logic          accept;

  // NOTE: every variable gets a default at the top of always_comb, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    phase = PH_IDLE;
    if (started) begin
      if (sample_cnt_q == batch_m1_q)  phase = PH_LAST;
      else if (sample_cnt_q == '0)     phase = PH_FIRST;
      else                             phase = PH_MID;
    end
  end

  assign accept = gradient_valid && (phase != PH_IDLE);

  always_comb begin
    word_cnt_d   = word_cnt_q;
    sample_cnt_d = sample_cnt_q;
    if (!started) begin
      word_cnt_d   = '0;
      sample_cnt_d = '0;
    end else if (accept) begin
      if (word_cnt_q == words_m1_q) begin
        word_cnt_d   = '0;
        sample_cnt_d = (sample_cnt_q == batch_m1_q) ? '0 : sample_cnt_q + 32'd1;
      end else begin
        word_cnt_d = word_cnt_q + AW'(1);
      end
    end
  end

  // Pipeline stages.
  beat_t                 beat_d, s1_q, s2_q;
  logic                  s1_valid_q, s2_valid_q;
  logic [LANE_VEC_W-1:0] ram_rdata, opnd_d, s2_opnd_q, sum_w;
  logic                  wr_en;
  logic                  wb_valid_q;
  logic [AW-1:0]         wb_addr_q;
  logic [LANE_VEC_W-1:0] wb_data_q;
  logic                  acc_valid_q;
  logic [LANE_VEC_W-1:0] acc_q;

  // sample_cnt==0 also covers batch_size 1, where the beat is both FIRST and LAST.
  assign beat_d = '{addr:  word_cnt_q,
                    first: (sample_cnt_q == '0),
                    last:  (phase == PH_LAST),
                    grad:  gradient};

  assign sum_w = add_lanes(s2_opnd_q, s2_q.grad);
  assign wr_en = s2_valid_q && !s2_q.last;

  // The RAM word read for the beat in C1 misses writes from the two beats
  // ahead of it: the one in C2 (not yet written) and the one written on the
  // edge that captured the read (read-first). The newer one wins.
  always_comb begin
    opnd_d = ram_rdata;
    if (s1_q.first)                               opnd_d = '0;
    else if (wr_en && s2_q.addr == s1_q.addr)     opnd_d = sum_w;
    else if (wb_valid_q && wb_addr_q == s1_q.addr) opnd_d = wb_data_q;
  end

  sgd_acc_bram #(
    .ADDR_W (AW),
    .DATA_W (LANE_VEC_W)
  ) u_bram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (s2_q.addr),
    .wdata_i (sum_w),
    .raddr_i (word_cnt_q),
    .rdata_o (ram_rdata)
  );

  // Control state with reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_q   <= '0;
      sample_cnt_q <= '0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      acc_valid_q  <= 1'b0;
      acc_q        <= '0;
    end else begin
      word_cnt_q   <= word_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      s1_valid_q   <= accept;
      s2_valid_q   <= s1_valid_q;
      wb_valid_q   <= wr_en;
      acc_valid_q  <= s2_valid_q && s2_q.last;
      if (s2_valid_q && s2_q.last) begin
        acc_q <= sum_w;
      end
    end
  end

  // Data path and configuration; qualified by the valids above, so no reset.
  always_ff @(posedge clk) begin
    words_m1_q <= words_m1_w[AW-1:0];
    batch_m1_q <= (batch_size == '0) ? '0 : batch_size - 32'd1;
    s1_q       <= beat_d;
    s2_q       <= s1_q;
    s2_opnd_q  <= opnd_d;
    if (wr_en) begin
      wb_addr_q <= s2_q.addr;
      wb_data_q <= sum_w;
    end
  end

  assign acc_gradient       = acc_q;
  assign acc_gradient_valid = {NUM_BITS_PER_BANK{acc_valid_q}};

endmodule

// File: tb/tb_sgd_gradient_batch_acc.sv
module tb_sgd_gradient_batch_acc;
  import sgd_pkg::*;

  localparam int VW = LANE_VEC_W;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         started;
  logic [31:0]                  dimension;
  logic [31:0]                  batch_size;
  logic [VW-1:0]                gradient;
  logic                         gradient_valid;
  logic [VW-1:0]                acc_gradient;
  logic [NUM_BITS_PER_BANK-1:0] acc_gradient_valid;

  sgd_gradient_batch_acc dut (
    .clk                (clk),
    .rst                (rst),
    .started            (started),
    .dimension          (dimension),
    .batch_size         (batch_size),
    .gradient           (gradient),
    .gradient_valid     (gradient_valid),
    .acc_gradient       (acc_gradient),
    .acc_gradient_valid (acc_gradient_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected outputs: cycle at which valid must be seen, and the lane data.
  typedef struct {
    int            cyc;
    logic [VW-1:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [VW-1:0] lanes_lin(input logic [31:0] a, input logic [31:0] b);
    logic [VW-1:0] v;
    for (int i = 0; i < NUM_BITS_PER_BANK; i++) v[i*32 +: 32] = a + b * 32'(i);
    return v;
  endfunction

  always @(negedge clk) begin
    if (acc_gradient_valid !== '0) begin
      check("valid_lanes", 32'(acc_gradient_valid), 32'((1 << NUM_BITS_PER_BANK) - 1));
      check("out_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
        for (int i = 0; i < NUM_BITS_PER_BANK; i++)
          check($sformatf("lane%0d", i), acc_gradient[i*32 +: 32], mon_e.data[i*32 +: 32]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic config_job(input logic [31:0] dim, input logic [31:0] bs);
    started    = 1'b0;
    dimension  = dim;
    batch_size = bs;
    step(2);
    started = 1'b1;
  endtask

  // One beat in the current cycle; an expected output 3 cycles later if asked.
  task automatic send(input logic [VW-1:0] g, input bit expect_out, input logic [VW-1:0] exp);
    exp_t e;
    gradient       = g;
    gradient_valid = 1'b1;
    if (expect_out) begin
      e.cyc  = cyc + 3;
      e.data = exp;
      exp_q.push_back(e);
    end
    step(1);
    gradient_valid = 1'b0;
  endtask

  task automatic gapped_batch();
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 2; w++) begin
        send(lanes_lin(32'((s + 1) * (10 * w + 1)), 32'(s + 1)), s == 2,
             lanes_lin(32'(6 * (10 * w + 1)), 32'd6));
        step(int'($urandom_range(0, 3)));
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    started        = 1'b0;
    gradient       = '0;
    gradient_valid = 1'b0;
    dimension      = 32'd64;
    batch_size     = 32'd1;
    step(3);
    check("rst_valid", 32'(acc_gradient_valid), 32'd0);
    check("rst_acc", 32'(|acc_gradient), 32'd0);
    rst = 1'b0;
    step(1);

    // Steady batch: words=1, batch 4, lane i of beat k = k(1+i).
    config_job(32'd64, 32'd4);
    for (int k = 1; k <= 4; k++) send(lanes_lin(32'(k), 32'(k)), k == 4, lanes_lin(32'd10, 32'd10));
    step(6);

    // Multi-word (dimension 500 rounds up to 8 words), batch 3, two batches.
    config_job(32'd500, 32'd3);
    for (int b = 0; b < 2; b++)
      for (int s = 0; s < 3; s++)
        for (int w = 0; w < 8; w++)
          send(lanes_lin(32'(w), 32'd1), s == 2, lanes_lin(32'(3 * w), 32'd3));
    step(6);

    // Hazard, words=1: 5 x 0x7FFFFFFF wraps to 0x7FFFFFFB.
    config_job(32'd64, 32'd5);
    for (int k = 0; k < 5; k++)
      send(lanes_lin(32'h7FFF_FFFF, 32'd0), k == 4, lanes_lin(32'h7FFF_FFFB, 32'd0));
    step(6);

    // Hazard, words=2, with negative lanes.
    config_job(32'd128, 32'd3);
    for (int s = 0; s < 3; s++) begin
      send(lanes_lin(32'd1, 32'd1), s == 2, lanes_lin(32'd3, 32'd3));
      send(lanes_lin(-32'sd5, -32'sd1), s == 2, lanes_lin(-32'sd15, -32'sd3));
    end
    step(6);

    // batch_size 0 then 1: every beat echoed.
    config_job(32'd128, 32'd0);
    for (int k = 0; k < 4; k++) send(lanes_lin(32'(7 * k), 32'd2), 1'b1, lanes_lin(32'(7 * k), 32'd2));
    step(6);
    config_job(32'd64, 32'd1);
    for (int k = 0; k < 3; k++) begin
      send(lanes_lin(32'(k + 40), -32'sd3), 1'b1, lanes_lin(32'(k + 40), -32'sd3));
      step(k);
    end
    step(6);

    // Reset two cycles after a LAST beat kills its output.
    config_job(32'd64, 32'd2);
    send(lanes_lin(32'd5, 32'd1), 1'b0, '0);
    send(lanes_lin(32'd6, 32'd1), 1'b0, '0);
    step(1);
    rst = 1'b1;
    step(1);
    check("rst_kill_valid", 32'(acc_gradient_valid), 32'd0);
    check("rst_kill_acc", 32'(|acc_gradient), 32'd0);
    step(1);
    rst = 1'b0;
    send(lanes_lin(32'd7, 32'd1), 1'b0, '0);
    send(lanes_lin(32'd8, 32'd1), 1'b1, lanes_lin(32'd15, 32'd2));
    step(6);

    // Gapped input, then a started drop mid-batch and a fresh batch.
    config_job(32'd128, 32'd3);
    gapped_batch();
    send(lanes_lin(32'd999, 32'd1), 1'b0, '0);
    send(lanes_lin(32'd999, 32'd1), 1'b0, '0);
    send(lanes_lin(32'd999, 32'd1), 1'b0, '0);
    step(1);
    started        = 1'b0;
    gradient       = lanes_lin(32'd77, 32'd0);
    gradient_valid = 1'b1;
    step(1);
    gradient_valid = 1'b0;
    step(3);
    started = 1'b1;
    gapped_batch();
    step(8);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
